// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and widths for the two-port memory bus arbiter.
package mem_bus_arbiter_pkg;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2,
        DONE    = 2'd3
    } state_t;

    typedef enum logic {
        GNT_I = 1'b0,
        GNT_D = 1'b1
    } gnt_t;
endpackage

// File: rtl/mem_bus_arbiter_pick.sv
// Combinational winner selection between the instruction and data ports.
// MEM_ARB_ROUND_ROBIN_EN selects alternating grants on contention; otherwise D has fixed priority.
module mem_arb_pick
    import mem_bus_arbiter_pkg::*;
(
    input  logic i_req,
    input  logic d_req,
    input  gnt_t last_gnt,
    output logic any_req,
    output gnt_t winner
);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        any_req = i_req | d_req;
        winner  = GNT_D;
        if (i_req && d_req) begin
            winner = (last_gnt == GNT_D) ? GNT_I : GNT_D;
        end else if (i_req) begin
            winner = GNT_I;
        end
    end
`else
    // Fixed priority ignores the grant history.
    logic last_gnt_unused;
    assign last_gnt_unused = last_gnt;

    always_comb begin
        any_req = i_req | d_req;
        winner  = GNT_D;
        if (i_req && !d_req) begin
            winner = GNT_I;
        end
    end
`endif
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates an instruction port and a data port onto one memory bus with a four-state FSM.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on contention instead of fixed D priority.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
(
    input  logic              CLK,
    input  logic              RESET,
    input  logic              I_READ,
    input  logic [ADDR_W-1:0] I_ADDRESS,
    output logic [DATA_W-1:0] I_READDATA,
    output logic              I_BUSYWAIT,
    input  logic              D_READ,
    input  logic              D_WRITE,
    input  logic [ADDR_W-1:0] D_ADDRESS,
    input  logic [DATA_W-1:0] D_WRITEDATA,
    output logic [DATA_W-1:0] D_READDATA,
    output logic              D_BUSYWAIT,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-1:0] MEM_ADDRESS,
    output logic [DATA_W-1:0] MEM_WRITEDATA,
    input  logic [DATA_W-1:0] MEM_READDATA,
    input  logic              MEM_BUSYWAIT,
    output state_t            dbg_state
);
    // Handshake: a port holds its request (I_READ, or D_READ/D_WRITE) until its BUSYWAIT is low;
    // BUSYWAIT is low only in the single DONE cycle after that port's transaction, then the port drops or re-issues.
    state_t            state_q, state_d;
    gnt_t              last_gnt_q, last_gnt_d;
    logic              entered_q, entered_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_writedata_q, mem_writedata_d;
    logic [DATA_W-1:0] i_readdata_q, i_readdata_d;
    logic [DATA_W-1:0] d_readdata_q, d_readdata_d;
    logic              any_req;
    gnt_t              winner;

    mem_arb_pick u_pick (
        .i_req    (I_READ),
        .d_req    (D_READ | D_WRITE),
        .last_gnt (last_gnt_q),
        .any_req  (any_req),
        .winner   (winner)
    );

    always_comb begin
        state_d         = state_q;
        last_gnt_d      = last_gnt_q;
        entered_d       = entered_q;
        mem_read_d      = mem_read_q;
        mem_write_d     = mem_write_q;
        mem_address_d   = mem_address_q;
        mem_writedata_d = mem_writedata_q;
        i_readdata_d    = i_readdata_q;
        d_readdata_d    = d_readdata_q;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    entered_d  = 1'b1;
                    last_gnt_d = winner;
                    if (winner == GNT_D) begin
                        state_d         = GRANT_D;
                        mem_write_d     = D_WRITE;
                        mem_read_d      = D_READ & ~D_WRITE;
                        mem_address_d   = D_ADDRESS;
                        mem_writedata_d = D_WRITEDATA;
                    end else begin
                        state_d       = GRANT_I;
                        mem_read_d    = 1'b1;
                        mem_write_d   = 1'b0;
                        mem_address_d = I_ADDRESS;
                    end
                end
            end
            GRANT_I, GRANT_D: begin
                // Bus command is latched at entry, so a dropped request still finishes its transaction.
                // entered_q keeps the edge that enters GRANT from ever counting as completion.
                if (entered_q && !MEM_BUSYWAIT) begin
                    state_d     = DONE;
                    entered_d   = 1'b0;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read_q && (state_q == GRANT_I)) i_readdata_d = MEM_READDATA;
                    if (mem_read_q && (state_q == GRANT_D)) d_readdata_d = MEM_READDATA;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q         <= IDLE;
            last_gnt_q      <= GNT_I;
            entered_q       <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            mem_address_q   <= '0;
            mem_writedata_q <= '0;
            i_readdata_q    <= '0;
            d_readdata_q    <= '0;
        end else begin
            state_q         <= state_d;
            last_gnt_q      <= last_gnt_d;
            entered_q       <= entered_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            mem_address_q   <= mem_address_d;
            mem_writedata_q <= mem_writedata_d;
            i_readdata_q    <= i_readdata_d;
            d_readdata_q    <= d_readdata_d;
        end
    end

    assign I_BUSYWAIT    = I_READ & ~((state_q == DONE) && (last_gnt_q == GNT_I));
    assign D_BUSYWAIT    = (D_READ | D_WRITE) & ~((state_q == DONE) && (last_gnt_q == GNT_D));
    assign MEM_READ      = mem_read_q;
    assign MEM_WRITE     = mem_write_q;
    assign MEM_ADDRESS   = mem_address_q;
    assign MEM_WRITEDATA = mem_writedata_q;
    assign I_READDATA    = i_readdata_q;
    assign D_READDATA    = d_readdata_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model (arbitration rule, latency arithmetic, memory array).
`timescale 1ns/1ps
module tb_mem_bus_arbiter;
  import mem_bus_arbiter_pkg::*;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic i_read, d_read, d_write;
  logic [31:0] i_address, d_address, d_writedata;
  logic [31:0] i_readdata, d_readdata;
  logic i_busywait, d_busywait;
  logic mem_read, mem_write;
  logic [31:0] mem_address, mem_writedata;
  logic [31:0] mem_readdata;
  logic mem_busywait;
  state_t dbg_state;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .CLK(clk), .RESET(rst),
    .I_READ(i_read), .I_ADDRESS(i_address), .I_READDATA(i_readdata), .I_BUSYWAIT(i_busywait),
    .D_READ(d_read), .D_WRITE(d_write), .D_ADDRESS(d_address), .D_WRITEDATA(d_writedata),
    .D_READDATA(d_readdata), .D_BUSYWAIT(d_busywait),
    .MEM_READ(mem_read), .MEM_WRITE(mem_write), .MEM_ADDRESS(mem_address),
    .MEM_WRITEDATA(mem_writedata), .MEM_READDATA(mem_readdata), .MEM_BUSYWAIT(mem_busywait),
    .dbg_state(dbg_state)
  );

  int pass_cnt = 0;
  int fail_cnt = 0;
  int check_cnt = 0;

  // scoreboard: bus addresses expected on the memory side, in grant order
  logic [31:0] exp_q[$];
  logic [31:0] mem_m [logic [31:0]];
  logic [31:0] exp_i_rd, exp_d_rd;
  gnt_t last_model;
  logic [31:0] cur_i_addr, cur_d_addr;
  int wait_i, wait_d;
  bit mem_active, new_txn;
  int mem_rem;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_lookup(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return {a[15:0], a[31:16]} ^ 32'h0BAD_F00D;
  endfunction

  function automatic gnt_t pick_model(input bit i_req, input bit d_req);
    if (i_req && d_req) return (RR_EN && last_model == GNT_D) ? GNT_I : GNT_D;
    return i_req ? GNT_I : GNT_D;
  endfunction

  // memory model: busy for the configured number of cycles from the first granted cycle
  task automatic mem_step();
    new_txn = 1'b0;
    if (mem_read || mem_write) begin
      if (!mem_active) begin
        mem_active = 1'b1;
        new_txn = 1'b1;
        mem_rem = (mem_address == cur_d_addr) ? wait_d : wait_i;
      end
      mem_busywait = (mem_rem > 0);
      if (mem_rem > 0) mem_rem--;
      mem_readdata = mem_lookup(mem_address);
    end else begin
      mem_active = 1'b0;
      mem_busywait = 1'b0;
    end
  endtask

  task automatic run_case(input bit i_rd, input bit d_rd, input bit d_wr,
                          input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                          input int wi, input int wd, input string tag);
    bit d_req, both;
    gnt_t first;
    int lat_i, lat_d, max_lat, got_i, got_d, cyc_i, cyc_d;
    logic [31:0] new_i_rd, new_d_rd;
    d_req = d_rd | d_wr;
    both = i_rd && d_req;
    first = pick_model(i_rd, d_req);
    lat_i = -1; lat_d = -1;
    if (first == GNT_I) begin
      lat_i = 2 + wi;
      if (both) lat_d = 5 + wi + wd;
    end else begin
      lat_d = 2 + wd;
      if (both) lat_i = 5 + wd + wi;
    end
    max_lat = (lat_i > lat_d) ? lat_i : lat_d;
    exp_q.delete();
    if (first == GNT_I) exp_q.push_back(ia); else exp_q.push_back(da);
    if (both) exp_q.push_back((first == GNT_I) ? da : ia);
    new_i_rd = i_rd ? mem_lookup(ia) : exp_i_rd;
    new_d_rd = (d_rd && !d_wr) ? mem_lookup(da) : exp_d_rd;
    cur_i_addr = ia; cur_d_addr = da; wait_i = wi; wait_d = wd;
    i_read = i_rd; i_address = ia;
    d_read = d_rd; d_write = d_wr; d_address = da; d_writedata = dwd;
    got_i = -1; got_d = -1; cyc_i = 0; cyc_d = 0;
    #1;
    for (int k = 0; k < 40; k++) begin
      mem_step();
      if (new_txn) begin
        check({tag, "_addr"}, mem_address, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX);
        if (mem_address == da) begin
          check({tag, "_dwr"}, {30'd0, mem_read, mem_write}, {30'd0, d_rd & ~d_wr, d_wr});
          if (d_wr) check({tag, "_wdata"}, mem_writedata, dwd);
        end else begin
          check({tag, "_ird"}, {30'd0, mem_read, mem_write}, 32'd2);
        end
      end
      if (mem_read || mem_write) begin
        if (mem_address == ia) cyc_i++;
        if (mem_address == da) cyc_d++;
      end
      if (k == 1) check({tag, "_entry"}, dbg_state, (first == GNT_I) ? GRANT_I : GRANT_D);
      if (i_read && !i_busywait && got_i < 0) begin
        got_i = k;
        check({tag, "_irdata"}, i_readdata, new_i_rd);
        i_read = 1'b0;
      end
      if ((d_read || d_write) && !d_busywait && got_d < 0) begin
        got_d = k;
        check({tag, "_drdata"}, d_readdata, new_d_rd);
        d_read = 1'b0; d_write = 1'b0;
      end
      if (k >= max_lat + 1) break;
      @(negedge clk);
    end
    if (i_rd) begin
      check({tag, "_ilat"}, got_i, lat_i);
      check({tag, "_icyc"}, cyc_i, wi + 1);
    end
    if (d_req) begin
      check({tag, "_dlat"}, got_d, lat_d);
      check({tag, "_dcyc"}, cyc_d, wd + 1);
    end
    if (d_wr) mem_m[da] = dwd;
    exp_i_rd = new_i_rd;
    exp_d_rd = new_d_rd;
    last_model = both ? ((first == GNT_I) ? GNT_D : GNT_I) : first;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
  endtask

  initial begin
    int grants;
    gnt_t w;
    bit r_i;
    int r_d;
    rst = 1'b1;
    i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
    i_address = '0; d_address = '0; d_writedata = '0;
    mem_readdata = '0; mem_busywait = 1'b0;
    mem_active = 1'b0; new_txn = 1'b0; mem_rem = 0;
    cur_i_addr = 32'hFFFF_FFF0; cur_d_addr = 32'hFFFF_FFFC; wait_i = 0; wait_d = 0;
    exp_i_rd = '0; exp_d_rd = '0; last_model = GNT_I;
    repeat (2) @(negedge clk);
    check("rst_state", dbg_state, IDLE);
    check("rst_mem_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_maddr", mem_address, 32'h0);
    check("rst_mwdata", mem_writedata, 32'h0);
    check("rst_irdata", i_readdata, 32'h0);
    check("rst_drdata", d_readdata, 32'h0);
    check("rst_busy", {30'd0, i_busywait, d_busywait}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // single I read with two busy cycles
    mem_m[32'h100] = 32'hDEAD_BEEF;
    run_case(1, 0, 0, 32'h100, 32'hFFFF_FFFC, 32'h0, 2, 0, "iread");
    // simultaneous I read and D write
    run_case(1, 0, 1, 32'h300, 32'h200, 32'h1234_5678, 1, 1, "both");
    // read back the write, then read+write together must act as a write
    run_case(0, 1, 0, 32'hFFFF_FFF0, 32'h200, 32'h0, 1, 0, "drback");
    run_case(0, 1, 1, 32'hFFFF_FFF0, 32'h204, 32'hCAFE_F00D, 0, 1, "drw");
    // zero-wait memory on both ports
    run_case(1, 1, 0, 32'h400, 32'h204, 32'h0, 0, 0, "zwait");

    // both ports requesting continuously for four grants
    cur_i_addr = 32'h1000_0040; cur_d_addr = 32'h2000_0080; wait_i = 0; wait_d = 0;
    exp_q.delete();
    for (int g = 0; g < 4; g++) begin
      w = pick_model(1'b1, 1'b1);
      exp_q.push_back((w == GNT_I) ? cur_i_addr : cur_d_addr);
      last_model = w;
    end
    i_read = 1'b1; i_address = cur_i_addr;
    d_read = 1'b0; d_write = 1'b1; d_address = cur_d_addr; d_writedata = 32'h5555_AAAA;
    grants = 0;
    #1;
    for (int k = 0; k < 40; k++) begin
      mem_step();
      if (new_txn) begin
        grants++;
        check("cont_order", mem_address, (exp_q.size() > 0) ? exp_q.pop_front() : 32'hXXXX_XXXX);
      end
      if (grants == 4 && !mem_active) break;
      @(negedge clk);
    end
    i_read = 1'b0; d_write = 1'b0;
    check("cont_grants", grants, 4);
    mem_m[cur_d_addr] = 32'h5555_AAAA;
    repeat (2) begin
      @(negedge clk);
      mem_step();
    end
    check("cont_idle", dbg_state, IDLE);

    // request dropped mid-grant still completes
    cur_i_addr = 32'h1000_0100; cur_d_addr = 32'hFFFF_FFFC; wait_i = 1;
    i_read = 1'b1; i_address = cur_i_addr;
    grants = -1;
    #1;
    for (int k = 0; k < 12; k++) begin
      mem_step();
      if (k == 1) i_read = 1'b0;
      if (dbg_state == DONE) begin
        grants = k;
        break;
      end
      @(negedge clk);
    end
    check("drop_done", grants, 3);
    exp_i_rd = mem_lookup(cur_i_addr);
    check("drop_rdata", i_readdata, exp_i_rd);
    last_model = GNT_I;
    @(negedge clk);
    mem_step();
    check("drop_idle", dbg_state, IDLE);

    // randomized traffic
    for (int n = 0; n < 16; n++) begin
      r_i = 1'($urandom_range(0, 1));
      r_d = $urandom_range(0, 3);
      if (!r_i && r_d == 0) r_i = 1'b1;
      run_case(r_i, (r_d == 1) || (r_d == 3), (r_d == 2) || (r_d == 3),
               32'h1000_0000 | (32'($urandom_range(0, 255)) << 2),
               32'h2000_0000 | (32'($urandom_range(0, 3)) << 2),
               $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "rand");
    end

    // reset in the second cycle of GRANT_D aborts the transaction
    cur_d_addr = 32'h2000_0100; wait_d = 6;
    d_read = 1'b1; d_write = 1'b0; d_address = cur_d_addr;
    #1;
    mem_step();
    @(negedge clk);
    mem_step();
    check("rst_gnt_entry", dbg_state, GRANT_D);
    @(negedge clk);
    mem_step();
    rst = 1'b1;
    @(negedge clk);
    check("rst_abort_state", dbg_state, IDLE);
    check("rst_abort_rw", {30'd0, mem_read, mem_write}, 32'd0);
    check("rst_abort_irdata", i_readdata, 32'h0);
    check("rst_abort_drdata", d_readdata, 32'h0);
    rst = 1'b0;
    d_read = 1'b0;
    mem_step();
    @(negedge clk);
    mem_step();
    check("rst_no_done", dbg_state, IDLE);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
